// File: rtl/ccsds_turbo_paddr_gen_pkg.sv
// Shared types, default tables and FSM encodings for the CCSDS turbo
// permutation address generator.
package ccsds_turbo_paddr_gen_pkg;

   localparam int unsigned cPW       = 13;
   localparam int unsigned cNIDX_DEF = 4;
   localparam int unsigned cROW_DEF  = 4;

   typedef logic [cPW-1:0] ptab_dat_t;

   localparam int unsigned cK2_TAB_DEF [cNIDX_DEF] = '{223, 446, 892, 1115};
   localparam int unsigned cP_TAB_DEF  [cROW_DEF]  = '{31, 37, 43, 47};

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/ccsds_turbo_paddr_acc.sv
// One per-row modular accumulator: acc <- (acc + step) mod K2 on each advance.
// o_cur_c is the value to emit this cycle (the init value while loading).
module ccsds_turbo_paddr_acc
   import ccsds_turbo_paddr_gen_pkg::*;
#(
   parameter int unsigned pW = 13
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clkena,
   input  logic          i_load,
   input  logic          i_adv,
   input  logic [pW-1:0] i_init,
   input  logic [pW-1:0] i_step,
   input  logic [pW-1:0] i_k2,
   output logic [pW-1:0] o_cur_c
);

   logic [pW-1:0] r_acc;
   logic [pW-1:0] r_step;
   logic [pW-1:0] w_base;
   logic [pW-1:0] w_stp;
   logic [pW-1:0] w_sum;
   logic [pW-1:0] w_wrap;

   // Both operands are below K2, so one conditional subtract is enough.
   always_comb begin
      w_base = i_load ? i_init : r_acc;
      w_stp  = i_load ? i_step : r_step;
      w_sum  = w_base + w_stp;
      w_wrap = (w_sum >= i_k2) ? (w_sum - i_k2) : w_sum;
   end

   assign o_cur_c = w_base;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_step <= '0;
      end else if (i_clkena) begin
         if (i_load) begin
            r_step <= i_step;
            r_acc  <= i_adv ? w_wrap : i_init;
         end else if (i_adv) begin
            r_acc  <= w_wrap;
         end
      end
   end

endmodule

// File: rtl/ccsds_turbo_paddr_gen.sv
// CCSDS turbo permutation address generator: streams one interleaved address
// per cycle, forward or exact reverse order, using per-row modular accumulators.
module ccsds_turbo_paddr_gen
   import ccsds_turbo_paddr_gen_pkg::*;
#(
   parameter int unsigned pROW  = 4,
   parameter int unsigned pNIDX = 4,
   parameter int unsigned pW    = 13,
   parameter int unsigned pK2_TAB [pNIDX] = cK2_TAB_DEF,
   parameter int unsigned pP_TAB  [pROW]  = cP_TAB_DEF
) (
   input  logic                       iclk,
   input  logic                       ireset,
   input  logic                       iclkena,
   input  logic                       istart,
   input  logic [$clog2(pNIDX)-1:0]   inidx,
   input  logic                       ibackward,
   input  logic                       iabort,
   input  logic                       iready,
   output logic                       ordy,
   output logic                       oval,
   output logic [pW-1:0]              oaddr,
   output logic                       osop,
   output logic                       oeop,
   output logic [pW-1:0]              oN
);

   localparam int unsigned cRW = $clog2(pROW);
   localparam int unsigned cAW = pW - cRW;

   // Elaboration-time parameter sanity.
   if (pROW < 2 || (pROW & (pROW - 1)) != 0) begin : g_chk_row
      $error("pROW must be a power of two >= 2");
   end
   if (pNIDX < 2) begin : g_chk_nidx
      $error("pNIDX must be >= 2");
   end
   for (genvar i = 0; i < pNIDX; i++) begin : g_chk_k2
      if (pROW * pK2_TAB[i] > (1 << pW)) begin : g_chk_n
         $error("pROW*K2 exceeds the address range");
      end
      for (genvar j = 0; j < pROW; j++) begin : g_chk_p
         if (pP_TAB[j] >= pK2_TAB[i]) begin : g_chk_pk
            $error("P must be smaller than every K2");
         end
      end
   end

   logic [1:0]     r_state, w_state_nxt;
   logic           r_bwd,   w_bwd_nxt;
   logic [pW-1:0]  r_k2,    w_k2_nxt;
   logic [pW-1:0]  r_n,     w_n_nxt;
   logic [pW-1:0]  r_col,   w_col_nxt;
   logic [pW-1:0]  r_addr,  w_addr_nxt;
   logic [cRW-1:0] r_row,   w_row_nxt;
   logic           r_rdy,   w_rdy_nxt;
   logic           r_val,   w_val_nxt;
   logic           r_sop,   w_sop_nxt;
   logic           r_eop,   w_eop_nxt;

   logic           w_load;
   logic           w_emit;
   logic           w_last_row;
   logic           w_last_col;
   logic [pW-1:0]  w_cur [pROW];
   logic [pW-1:0]  w_cur_row;

   // LOAD emits the first address; RUN emits the next one when the current is taken.
   assign w_load     = (r_state == ST_LOAD) && !iabort;
   assign w_emit     = w_load || ((r_state == ST_RUN) && !iabort && iready && !r_eop);
   assign w_last_row = r_bwd ? (r_row == '0) : (r_row == cRW'(pROW - 1));
   assign w_last_col = (r_col == (r_k2 - pW'(1)));
   assign w_cur_row  = w_cur[r_row];

   for (genvar g = 0; g < pROW; g++) begin : g_acc
      logic [pW-1:0] w_p;
      logic [pW-1:0] w_step;
      logic [pW-1:0] w_init;

      // Backward runs with the complementary step, starting at column K2-1.
      assign w_p    = pW'(pP_TAB[g]);
      assign w_step = r_bwd ? (r_k2 - w_p) : w_p;
      assign w_init = r_bwd ? w_step : '0;

      ccsds_turbo_paddr_acc #(
         .pW (pW)
      ) u_acc (
         .clk      (iclk),
         .rst_n    (ireset),
         .i_clkena (iclkena),
         .i_load   (w_load),
         .i_adv    (w_emit && (r_row == cRW'(g))),
         .i_init   (w_init),
         .i_step   (w_step),
         .i_k2     (r_k2),
         .o_cur_c  (w_cur[g])
      );
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bwd_nxt   = r_bwd;
      w_k2_nxt    = r_k2;
      w_n_nxt     = r_n;
      w_col_nxt   = r_col;
      w_addr_nxt  = r_addr;
      w_row_nxt   = r_row;
      w_rdy_nxt   = r_rdy;
      w_val_nxt   = r_val;
      w_sop_nxt   = r_sop;
      w_eop_nxt   = r_eop;

      case (r_state)
         ST_IDLE: begin
            if (istart && r_rdy) begin
               w_state_nxt = ST_LOAD;
               w_rdy_nxt   = 1'b0;
               w_bwd_nxt   = ibackward;
               w_k2_nxt    = pW'(pK2_TAB[inidx]);
               w_row_nxt   = ibackward ? cRW'(pROW - 1) : '0;
               w_col_nxt   = '0;
            end
         end
         ST_LOAD: begin
            if (iabort) begin
               w_state_nxt = ST_IDLE;
               w_rdy_nxt   = 1'b1;
            end else begin
               w_state_nxt = ST_RUN;
               w_n_nxt     = r_k2 << cRW;
            end
         end
         ST_RUN: begin
            if (iabort || (iready && r_eop)) begin
               w_state_nxt = ST_IDLE;
               w_rdy_nxt   = 1'b1;
               w_val_nxt   = 1'b0;
               w_sop_nxt   = 1'b0;
               w_eop_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_rdy_nxt   = 1'b1;
            w_val_nxt   = 1'b0;
            w_sop_nxt   = 1'b0;
            w_eop_nxt   = 1'b0;
         end
      endcase

      // Address = acc*pROW + row, built as a concatenation.
      if (w_emit) begin
         w_val_nxt  = 1'b1;
         w_sop_nxt  = (r_state == ST_LOAD);
         w_eop_nxt  = w_last_row && w_last_col;
         w_addr_nxt = {w_cur_row[cAW-1:0], r_row};
         w_row_nxt  = r_bwd ? (r_row - cRW'(1)) : (r_row + cRW'(1));
         if (w_last_row) begin
            w_col_nxt = r_col + pW'(1);
         end
      end
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         r_state <= ST_IDLE;
         r_bwd   <= 1'b0;
         r_k2    <= '0;
         r_n     <= '0;
         r_col   <= '0;
         r_addr  <= '0;
         r_row   <= '0;
         r_rdy   <= 1'b1;
         r_val   <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
      end else if (iclkena) begin
         r_state <= w_state_nxt;
         r_bwd   <= w_bwd_nxt;
         r_k2    <= w_k2_nxt;
         r_n     <= w_n_nxt;
         r_col   <= w_col_nxt;
         r_addr  <= w_addr_nxt;
         r_row   <= w_row_nxt;
         r_rdy   <= w_rdy_nxt;
         r_val   <= w_val_nxt;
         r_sop   <= w_sop_nxt;
         r_eop   <= w_eop_nxt;
      end
   end

   assign ordy  = r_rdy;
   assign oval  = r_val;
   assign oaddr = r_addr;
   assign osop  = r_sop;
   assign oeop  = r_eop;
   assign oN    = r_n;

endmodule

// File: tb/tb_ccsds_turbo_paddr_gen.sv
// Directed bench for ccsds_turbo_paddr_gen: block table with hand-computed
// head/tail addresses, permutation scoreboard, stall, abort and reset sequences.
module tb_ccsds_turbo_paddr_gen;

   logic        iclk = 1'b0;
   logic        ireset;
   logic        iclkena;
   logic        istart;
   logic [1:0]  inidx;
   logic        ibackward;
   logic        iabort;
   logic        iready;
   logic        ordy;
   logic        oval;
   logic [12:0] oaddr;
   logic        osop;
   logic        oeop;
   logic [12:0] oN;

   ccsds_turbo_paddr_gen dut (
      .iclk      (iclk),
      .ireset    (ireset),
      .iclkena   (iclkena),
      .istart    (istart),
      .inidx     (inidx),
      .ibackward (ibackward),
      .iabort    (iabort),
      .iready    (iready),
      .ordy      (ordy),
      .oval      (oval),
      .oaddr     (oaddr),
      .osop      (osop),
      .oeop      (oeop),
      .oN        (oN)
   );

   always #5 iclk = ~iclk;

   typedef struct {
      int nidx;
      bit bwd;
      int n;
      int f0, f1, f2, f3;
      int l0, l1, l2, l3;
   } vec_t;

   vec_t tab [8];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   q_got [$];
   int   q_ref [$];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   // Runs one block; stall=1 randomises iready/iclkena and pokes istart mid-block.
   task automatic run_block(input vec_t v, input bit stall, input string tag);
      int   cyc;
      bit   seen_eop;
      bit   hold_chk;
      int   hold_addr;
      bit   hold_sop, hold_eop;
      int   sop_err, hold_err, perm_err;
      bit   en, rdy;
      bit   seen [8192];
      int   ef [4];
      int   el [4];
      int   sz;

      q_got.delete();
      seen_eop = 0; hold_chk = 0; sop_err = 0; hold_err = 0; perm_err = 0;
      hold_addr = 0; hold_sop = 0; hold_eop = 0;
      iclkena = 1'b1; iready = 1'b1;
      istart = 1'b1; inidx = 2'(v.nidx); ibackward = v.bwd;
      tick();
      istart = 1'b0; inidx = ~2'(v.nidx); ibackward = ~v.bwd;
      cyc = 0;
      while (!seen_eop && cyc < 20000) begin
         if (!stall && cyc == 0) check({tag, "_load_state"}, int'({ordy, oval}), 0);
         if (!stall && cyc == 1) begin
            check({tag, "_first_lat"}, int'({oval, osop}), 3);
            check({tag, "_oN"}, int'(oN), v.n);
         end
         if (hold_chk && !(oval && int'(oaddr) == hold_addr && osop == hold_sop && oeop == hold_eop))
            hold_err++;
         en  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         iclkena = en; iready = rdy;
         istart  = stall && (cyc % 5 == 2);
         if (oval && en && rdy) begin
            q_got.push_back(int'(oaddr));
            if (osop != (q_got.size() == 1)) sop_err++;
            if (oeop) seen_eop = 1;
         end
         hold_chk  = oval && !(en && rdy);
         hold_addr = int'(oaddr); hold_sop = osop; hold_eop = oeop;
         tick();
         cyc++;
      end
      istart = 1'b0; iclkena = 1'b1; iready = 1'b1;
      check({tag, "_eop_seen"}, int'(seen_eop), 1);
      check({tag, "_eop_idle"}, int'({ordy, oval}), 2);
      sz = q_got.size();
      check({tag, "_len"}, sz, v.n);
      check({tag, "_sop"}, sop_err, 0);
      if (stall) check({tag, "_stall_hold"}, hold_err, 0);
      foreach (q_got[i]) begin
         if (q_got[i] < 0 || q_got[i] >= v.n) perm_err++;
         else if (seen[q_got[i]]) perm_err++;
         else seen[q_got[i]] = 1'b1;
      end
      check({tag, "_perm"}, perm_err, 0);
      ef = '{v.f0, v.f1, v.f2, v.f3};
      el = '{v.l0, v.l1, v.l2, v.l3};
      if (sz >= 8) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_first%0d", tag, i), q_got[i], ef[i]);
            check($sformatf("%s_last%0d", tag, i), q_got[sz - 4 + i], el[i]);
         end
         if (!v.bwd) begin
            check({tag, "_a4"}, q_got[4], 124);
            check({tag, "_a5"}, q_got[5], 149);
            check({tag, "_a6"}, q_got[6], 174);
            check({tag, "_a7"}, q_got[7], 191);
         end
      end
   endtask

   initial begin
      int cnt;
      int cyc;
      int mism;

      tab[0] = '{0, 1'b0,  892,    0,    1,    2,    3,  768,  745,  722,  707};
      tab[1] = '{0, 1'b1,  892,  707,  722,  745,  768,    3,    2,    1,    0};
      tab[2] = '{1, 1'b0, 1784,    0,    1,    2,    3, 1660, 1637, 1614, 1599};
      tab[3] = '{1, 1'b1, 1784, 1599, 1614, 1637, 1660,    3,    2,    1,    0};
      tab[4] = '{2, 1'b0, 3568,    0,    1,    2,    3, 3444, 3421, 3398, 3383};
      tab[5] = '{2, 1'b1, 3568, 3383, 3398, 3421, 3444,    3,    2,    1,    0};
      tab[6] = '{3, 1'b0, 4460,    0,    1,    2,    3, 4336, 4313, 4290, 4275};
      tab[7] = '{3, 1'b1, 4460, 4275, 4290, 4313, 4336,    3,    2,    1,    0};

      ireset = 1'b0; iclkena = 1'b1; istart = 1'b0; inidx = '0;
      ibackward = 1'b0; iabort = 1'b0; iready = 1'b1;
      #12;
      check("rst_ordy", int'(ordy), 1);
      check("rst_oval", int'(oval), 0);
      check("rst_oaddr", int'(oaddr), 0);
      check("rst_oN", int'(oN), 0);
      check("rst_sop_eop", int'({osop, oeop}), 0);
      #2 ireset = 1'b1;
      tick();

      // iabort while idle must not disturb anything
      iabort = 1'b1; tick(); iabort = 1'b0;
      check("idle_abort", int'({ordy, oval}), 2);

      for (int k = 0; k < 8; k++)
         run_block(tab[k], 1'b0, $sformatf("blk%0d", k));

      // stalled run must reproduce the stall-free sequence
      run_block(tab[0], 1'b0, "ref");
      q_ref = q_got;
      run_block(tab[0], 1'b1, "stall");
      mism = (q_got.size() == q_ref.size()) ? 0 : 1;
      foreach (q_ref[i]) if (i < q_got.size() && q_got[i] != q_ref[i]) mism++;
      check("stall_vs_ref", mism, 0);

      // abort at address index 100 of a forward inidx=3 block
      istart = 1'b1; inidx = 2'd3; ibackward = 1'b0; iready = 1'b1;
      tick();
      istart = 1'b0;
      cnt = 0; cyc = 0;
      while (cnt < 100 && cyc < 1000) begin
         if (oval) cnt++;
         tick();
         cyc++;
      end
      check("abort_addr100", int'(oaddr), 3100);
      iabort = 1'b1;
      tick();
      iabort = 1'b0;
      check("abort_idle", int'({ordy, oval}), 2);
      run_block(tab[2], 1'b0, "after_abort");

      // abort during LOAD
      istart = 1'b1; inidx = 2'd1; ibackward = 1'b1;
      tick();
      istart = 1'b0; iabort = 1'b1;
      tick();
      iabort = 1'b0;
      check("load_abort_idle", int'({ordy, oval}), 2);
      repeat (3) tick();
      check("load_abort_quiet", int'(oval), 0);

      // asynchronous reset in the middle of a block
      istart = 1'b1; inidx = 2'd2; ibackward = 1'b0;
      tick();
      istart = 1'b0;
      repeat (50) tick();
      check("pre_reset_oval", int'(oval), 1);
      #2 ireset = 1'b0;
      #1;
      check("async_rst_val_rdy", int'({ordy, oval}), 2);
      check("async_rst_oaddr", int'(oaddr), 0);
      check("async_rst_oN", int'(oN), 0);
      check("async_rst_sop_eop", int'({osop, oeop}), 0);
      #3 ireset = 1'b1;
      tick();
      run_block(tab[0], 1'b0, "post_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
